arbitro_mem_dma: RTL and testbench

//  Arbiter and sequencer for the shared 32-word instruction/data memory (32-bit words, byte addresses, word index = dir[6:2]).

---
 rtl/mem_pkg.sv | 17 +
 rtl/decodificador_dir.sv | 16 +
 rtl/arbitro_mem_dma.sv | 129 ++++++++++++
 tb/tb_arbitro_mem_dma.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and address-field bounds for the instruction/data memory arbiter.
// Word index lives in dir[6:2]; the window field is dir[31:8].
package mem_pkg;

    typedef enum logic [1:0] {
        S_LIBRE = 2'd0,
        S_CPU   = 2'd1,
        S_DMA   = 2'd2
    } estado_t;

    localparam int IDX_MSB = 6;
    localparam int IDX_LSB = 2;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
    localparam int VEN_MSB = 31;
    localparam int VEN_LSB = 8;

endpackage

// File: rtl/decodificador_dir.sv
// Address decoder: word index plus alignment/window legality for one 32-bit byte address.
// Purely combinational; no backpressure.
module decodificador_dir
    import mem_pkg::*;
#(
    parameter logic [23:0] POS_INICIAL = 24'd0
) (
    input  logic [31:0]      dir,
    output logic             ok,
    output logic [IDX_W-1:0] indice
);

    assign ok     = (dir[1:0] == 2'b00) && (dir[VEN_MSB:VEN_LSB] == POS_INICIAL);
    assign indice = dir[IDX_MSB:IDX_LSB];

endmodule

// File: rtl/arbitro_mem_dma.sv
// Round-robin arbiter/sequencer between CPU fetch (single read beat) and DMA bursts.
// Acks are combinational from state and request; read data/valid and error pulses are registered.
module arbitro_mem_dma
    import mem_pkg::*;
#(
    parameter logic [23:0] POS_INICIAL = 24'd0,
    parameter int          MAX_RAFAGA  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_dir,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_dir,
    input  logic [31:0] dma_wdata,
    input  logic        dma_ultimo,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_cedido,
    output logic        err_dir,
    output logic [31:0] mem_dir,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(MAX_RAFAGA);
    localparam logic [CNT_W-1:0] CNT_TOPE = CNT_W'(MAX_RAFAGA - 1);

    estado_t          estado;
    logic             prio;
    logic [CNT_W-1:0] cnt;
    logic             ok;
    logic [IDX_W-1:0] indice_unused;

    always_comb begin
        mem_dir = '0;
        case (estado)
            S_CPU:   mem_dir = cpu_dir;
            S_DMA:   mem_dir = dma_dir;
            default: mem_dir = '0;
        endcase
    end

    // Legality is judged on the muxed address, so one decoder covers both requesters.
    decodificador_dir #(
        .POS_INICIAL (POS_INICIAL)
    ) u_dec (
        .dir    (mem_dir),
        .ok     (ok),
        .indice (indice_unused)
    );

    assign cpu_ack   = (estado == S_CPU) && cpu_req;
    assign dma_ack   = (estado == S_DMA) && dma_req;
    assign mem_we    = dma_ack && dma_we && ok;
    assign mem_wdata = (estado == S_DMA) ? dma_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= S_LIBRE;
            prio       <= 1'b0;
            cnt        <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_cedido <= 1'b0;
            err_dir    <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_cedido <= 1'b0;
            err_dir    <= 1'b0;
            case (estado)
                S_LIBRE: begin
                    // prio=0 favours the CPU on a tie, prio=1 the DMA.
                    if (cpu_req && (!dma_req || !prio)) begin
                        estado <= S_CPU;
                    end else if (dma_req) begin
                        estado <= S_DMA;
                    end
                end
                S_CPU: begin
                    estado <= S_LIBRE;
                    if (cpu_req) begin
                        cpu_rdata  <= ok ? mem_rdata : '0;
                        cpu_rvalid <= 1'b1;
                        err_dir    <= !ok;
                        prio       <= 1'b1;
                    end
                end
                S_DMA: begin
                    if (!dma_req) begin
                        estado <= S_LIBRE;
                    end else begin
                        err_dir <= !ok;
                        if (!dma_we) begin
                            dma_rdata  <= ok ? mem_rdata : '0;
                            dma_rvalid <= 1'b1;
                        end
                        if (dma_ultimo) begin
                            estado <= S_LIBRE;
                            prio   <= 1'b0;
                            cnt    <= '0;
                        end else if (cnt == CNT_TOPE) begin
                            // Saturated: only a waiting CPU can cut the burst here.
                            if (cpu_req) begin
                                estado     <= S_LIBRE;
                                prio       <= 1'b0;
                                cnt        <= '0;
                                dma_cedido <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: estado <= S_LIBRE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_mem_dma.sv
// Bench for arbitro_mem_dma: directed scenarios plus random traffic against a transaction-level model.
module tb_arbitro_mem_dma;

    localparam int MAX_RAFAGA = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_dir = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [31:0] dma_dir = '0;
    logic [31:0] dma_wdata = '0;
    logic        dma_ultimo = 1'b0;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        dma_cedido;
    logic        err_dir;
    logic [31:0] mem_dir;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    arbitro_mem_dma #(
        .POS_INICIAL (24'd0),
        .MAX_RAFAGA  (MAX_RAFAGA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_dir    (cpu_dir),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_dir    (dma_dir),
        .dma_wdata  (dma_wdata),
        .dma_ultimo (dma_ultimo),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_cedido (dma_cedido),
        .err_dir    (err_dir),
        .mem_dir    (mem_dir),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory array driven by the DUT, and an independent reference copy kept by the model.
    logic [31:0] mem_tb  [32];
    logic [31:0] ref_mem [32];
    assign mem_rdata = mem_tb[mem_dir[6:2]];
    always @(posedge clk) if (mem_we) mem_tb[mem_dir[6:2]] <= mem_wdata;

    int n_chk = 0;
    int n_err = 0;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: owner of the memory this cycle, who wins the next tie, beats in the open burst.
    int          m_owner = 0;     // 0 none, 1 cpu, 2 dma
    bit          m_turn_dma = 1'b0;
    int          m_beats = 0;
    bit          e_crv = 0, e_drv = 0, e_err = 0, e_ced = 0;
    logic [31:0] e_crd = '0, e_drd = '0;

    // Next-cycle stimulus, applied at the falling edge.
    logic        n_cpu_req = 0, n_dma_req = 0, n_dma_we = 0, n_dma_ult = 0;
    logic [31:0] n_cpu_dir = '0, n_dma_dir = '0, n_dma_wdata = '0;

    bit          g_cack, g_dack, o_cack, o_dack, o_ced, o_err, o_we;
    logic [31:0] o_mdir;

    function automatic bit dir_ok(input logic [31:0] d);
        return (d[1:0] == 2'b00) && (d[31:8] == 24'd0);
    endfunction

    function automatic logic [31:0] rand_dir();
        logic [31:0] d;
        d = {24'd0, 1'($urandom), 5'($urandom), 2'b00};
        case ($urandom_range(0, 7))
            0: d[1:0]  = 2'($urandom_range(1, 3));
            1: d[31:8] = 24'($urandom_range(1, 255));
            default: ;
        endcase
        return d;
    endfunction

    task automatic modelo_reset();
        m_owner = 0; m_turn_dma = 0; m_beats = 0;
        e_crv = 0; e_drv = 0; e_err = 0; e_ced = 0;
    endtask

    task automatic aplicar_entradas();
        @(negedge clk);
        cpu_req = n_cpu_req; cpu_dir = n_cpu_dir;
        dma_req = n_dma_req; dma_we = n_dma_we; dma_dir = n_dma_dir;
        dma_wdata = n_dma_wdata; dma_ultimo = n_dma_ult;
    endtask

    task automatic aplicar_reset();
        reset = 1'b1;
        #1;
        verificar("rst_cpu_ack", 32'(cpu_ack), 0);
        verificar("rst_dma_ack", 32'(dma_ack), 0);
        verificar("rst_mem_we", 32'(mem_we), 0);
        verificar("rst_mem_dir", mem_dir, 0);
        verificar("rst_regs", {28'd0, cpu_rvalid, dma_rvalid, err_dir, dma_cedido}, 0);
        modelo_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic paso();
        logic [31:0] sel;
        bit          okv;
        aplicar_entradas();
        #1;
        verificar("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        if (e_crv) verificar("cpu_rdata", cpu_rdata, e_crd);
        verificar("dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
        if (e_drv) verificar("dma_rdata", dma_rdata, e_drd);
        verificar("err_dir", 32'(err_dir), 32'(e_err));
        verificar("dma_cedido", 32'(dma_cedido), 32'(e_ced));
        g_cack = (m_owner == 1) && cpu_req;
        g_dack = (m_owner == 2) && dma_req;
        sel = (m_owner == 1) ? cpu_dir : (m_owner == 2) ? dma_dir : 32'd0;
        okv = dir_ok(sel);
        verificar("cpu_ack", 32'(cpu_ack), 32'(g_cack));
        verificar("dma_ack", 32'(dma_ack), 32'(g_dack));
        verificar("mem_dir", mem_dir, sel);
        verificar("mem_we", 32'(mem_we), 32'(g_dack && dma_we && okv));
        if (g_dack && dma_we && okv) verificar("mem_wdata", mem_wdata, dma_wdata);
        o_cack = cpu_ack; o_dack = dma_ack; o_ced = dma_cedido;
        o_err = err_dir; o_we = mem_we; o_mdir = mem_dir;
        // Expected registered results of this cycle's beat.
        e_crv = g_cack;
        e_crd = okv ? ref_mem[sel[6:2]] : 32'd0;
        e_drv = g_dack && !dma_we;
        e_drd = okv ? ref_mem[sel[6:2]] : 32'd0;
        e_err = (g_cack || g_dack) && !okv;
        e_ced = 0;
        if (g_dack && dma_we && okv) ref_mem[sel[6:2]] = dma_wdata;
        case (m_owner)
            0: begin
                if (cpu_req && (!dma_req || !m_turn_dma)) m_owner = 1;
                else if (dma_req) m_owner = 2;
            end
            1: begin
                if (cpu_req) m_turn_dma = 1;
                m_owner = 0;
            end
            default: begin
                if (!dma_req) begin
                    m_owner = 0;
                end else begin
                    m_beats++;
                    if (dma_ultimo) begin
                        m_owner = 0; m_turn_dma = 0; m_beats = 0;
                    end else if (m_beats >= MAX_RAFAGA && cpu_req) begin
                        m_owner = 0; m_turn_dma = 0; m_beats = 0; e_ced = 1;
                    end
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic entradas_cero();
        n_cpu_req = 0; n_dma_req = 0; n_dma_we = 0; n_dma_ult = 0;
        n_cpu_dir = '0; n_dma_dir = '0; n_dma_wdata = '0;
    endtask

    initial begin
        int paso_ack, acks_antes, cedidos, errores, we_visto, beat, rem, k;
        bit cpu_hecho, cpu_visto, cpu_act, dir_tras_cpu_ok;
        logic [31:0] dir_tras_cpu, base;
        byte grants[$];

        for (int i = 0; i < 32; i++) begin
            mem_tb[i]  = $urandom;
            ref_mem[i] = mem_tb[i];
        end
        @(negedge clk);
        #2;
        aplicar_reset();

        // CPU alone reading word 1.
        entradas_cero();
        n_cpu_req = 1; n_cpu_dir = 32'h04;
        paso_ack = -1;
        for (int s = 0; s < 5 && paso_ack < 0; s++) begin
            paso();
            if (o_cack) paso_ack = s;
        end
        verificar("cpu_ack_latency", 32'(paso_ack), 1);
        entradas_cero();
        paso();
        paso();

        // Tie from reset: grants alternate starting with the CPU.
        #3;
        aplicar_reset();
        n_cpu_req = 1; n_cpu_dir = 32'h08;
        n_dma_req = 1; n_dma_we = 0; n_dma_dir = 32'h0C; n_dma_ult = 1;
        for (int s = 0; s < 9; s++) begin
            paso();
            verificar("both_acks", 32'(o_cack && o_dack), 0);
            if (o_cack) grants.push_back("C");
            if (o_dack) grants.push_back("D");
        end
        for (int i = 0; i < 4; i++)
            verificar($sformatf("tie_grant_%0d", i), (i < grants.size()) ? 32'(grants[i]) : 0,
                      (i % 2 == 0) ? 32'("C") : 32'("D"));
        entradas_cero();
        paso();
        paso();

        // 12-beat write burst, CPU raises its request after beat 2 and must cut it at 8.
        beat = 0; cpu_hecho = 0; cpu_visto = 0; acks_antes = 0; cedidos = 0;
        dir_tras_cpu = '1; dir_tras_cpu_ok = 0;
        for (int s = 0; s < 60 && (beat < 12 || !cpu_hecho); s++) begin
            n_dma_req = (beat < 12); n_dma_we = 1; n_dma_dir = 32'(beat * 4);
            n_dma_wdata = 32'hA500_0000 + 32'(beat); n_dma_ult = (beat == 11);
            n_cpu_req = (beat >= 2) && !cpu_hecho; n_cpu_dir = 32'h40;
            paso();
            if (o_dack && !cpu_visto) acks_antes++;
            if (o_dack && cpu_visto && !dir_tras_cpu_ok) begin
                dir_tras_cpu = o_mdir; dir_tras_cpu_ok = 1;
            end
            if (o_ced) cedidos++;
            if (o_cack) cpu_visto = 1;
            if (g_dack) beat++;
            if (g_cack) cpu_hecho = 1;
        end
        entradas_cero();
        for (int s = 0; s < 2; s++) begin
            paso();
            if (o_ced) cedidos++;
        end
        verificar("burst_acks_before_cpu", 32'(acks_antes), MAX_RAFAGA);
        verificar("burst_cedido_pulses", 32'(cedidos), 1);
        verificar("burst_resume_dir", dir_tras_cpu, 32'h20);
        for (int i = 0; i < 12; i++)
            verificar($sformatf("burst_mem_%0d", i), mem_tb[i], 32'hA500_0000 + 32'(i));

        // Misaligned CPU read, then out-of-window DMA write.
        errores = 0; we_visto = 0;
        n_cpu_req = 1; n_cpu_dir = 32'h06;
        for (int s = 0; s < 6; s++) begin
            paso();
            if (o_err) errores++;
            if (o_we) we_visto++;
            if (g_cack) n_cpu_req = 0;
        end
        n_dma_req = 1; n_dma_we = 1; n_dma_dir = 32'h100; n_dma_wdata = 32'hDEAD_BEEF; n_dma_ult = 1;
        for (int s = 0; s < 6; s++) begin
            paso();
            if (o_err) errores++;
            if (o_we) we_visto++;
            if (g_dack) n_dma_req = 0;
        end
        verificar("bad_err_pulses", 32'(errores), 2);
        verificar("bad_mem_we", 32'(we_visto), 0);
        verificar("bad_mem_word0", mem_tb[0], 32'hA500_0000);

        // Reset asserted while the 4th beat of a burst is being acked.
        beat = 0;
        entradas_cero();
        for (int s = 0; s < 10 && beat < 3; s++) begin
            n_dma_req = 1; n_dma_we = 1; n_dma_dir = 32'h40 + 32'(beat * 4);
            n_dma_wdata = 32'h5A00_0000 + 32'(beat);
            paso();
            if (g_dack) beat++;
        end
        n_dma_dir = 32'h40 + 32'(beat * 4); n_dma_wdata = 32'h5A00_0000 + 32'(beat);
        aplicar_entradas();
        #1;
        verificar("midburst_ack_before_rst", 32'(dma_ack), 1);
        aplicar_reset();
        // Both request right after reset: CPU must be favoured.
        n_cpu_req = 1; n_cpu_dir = 32'h10; n_dma_req = 1; n_dma_we = 0; n_dma_ult = 1;
        paso();
        paso();
        verificar("post_rst_cpu_first", 32'(o_cack), 1);
        entradas_cero();
        paso();
        paso();

        // Single-beat burst with dma_ultimo and no CPU pending.
        cedidos = 0;
        n_dma_req = 1; n_dma_we = 0; n_dma_dir = 32'h14; n_dma_ult = 1;
        for (int s = 0; s < 4; s++) begin
            paso();
            if (o_ced) cedidos++;
            if (g_dack) entradas_cero();
        end
        verificar("ultimo_no_cedido", 32'(cedidos), 0);

        // Random traffic.
        cpu_act = 0; rem = 0; k = 0; base = '0;
        for (int s = 0; s < 1500; s++) begin
            if (!cpu_act && $urandom_range(0, 3) == 0) begin
                cpu_act = 1; n_cpu_dir = rand_dir();
            end
            n_cpu_req = cpu_act;
            if (rem == 0 && $urandom_range(0, 3) == 0) begin
                rem = $urandom_range(1, 12); k = 0; base = rand_dir();
                n_dma_we = 1'($urandom);
            end
            n_dma_req = (rem > 0) && ($urandom_range(0, 7) != 0);
            n_dma_dir = base + 32'(k * 4);
            if ($urandom_range(0, 15) == 0) n_dma_dir = rand_dir();
            n_dma_wdata = $urandom;
            n_dma_ult = (rem == 1);
            paso();
            verificar("rnd_both_acks", 32'(o_cack && o_dack), 0);
            if (g_cack) cpu_act = 0;
            if (g_dack) begin rem--; k++; end
        end
        entradas_cero();
        paso();
        paso();
        for (int i = 0; i < 32; i++)
            verificar($sformatf("final_mem_%0d", i), mem_tb[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
